// File: rtl/qam16_modulator_if.sv
// Symbol-in / sample-out bundle for the QAM-16 modulator.
// The master side drives symbols; the slave side is the modulator.
interface qam16_modulator_if #(
  parameter int unsigned width_sym = 16
);
  logic [3:0]           sym_in;
  logic                 sym_valid;
  logic                 sym_ready;
  logic [width_sym-1:0] data_out;
  logic                 data_valid;
  logic [3:0]           phase;
  logic                 sym_start;

  modport master (
    output sym_in,
    output sym_valid,
    input  sym_ready,
    input  data_out,
    input  data_valid,
    input  phase,
    input  sym_start
  );

  modport slave (
    input  sym_in,
    input  sym_valid,
    output sym_ready,
    output data_out,
    output data_valid,
    output phase,
    output sym_start
  );
endinterface

// File: rtl/qam16_modulator.sv
// QAM-16 modulator: Gray-maps a 4-bit symbol to I/Q levels and emits 16 carrier samples
// I*cos + Q*sin per symbol, one per clock, with gapless back-to-back symbol acceptance.
module qam16_modulator #(
  parameter int unsigned width_sym = 16,
  parameter int unsigned SHIFT     = 3
) (
  input logic              clk,
  input logic              rst_n,
  qam16_modulator_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic signed [2:0]    i_q, i_d;
  logic signed [2:0]    q_q, q_d;
  logic [width_sym-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic [3:0]           phase_q, phase_d;
  logic                 start_q, start_d;

  logic                 last;
  logic                 ready;
  logic                 accept;
  logic signed [15:0]   sin_c;
  logic signed [15:0]   cos_c;
  logic signed [18:0]   prod_i;
  logic signed [18:0]   prod_q;
  logic signed [19:0]   sum;
  logic [width_sym-1:0] sample;

  // Quarter-wave symmetric sine table in Q1.14; second half is the negated first half.
  function automatic logic signed [15:0] coef(input logic [3:0] k);
    logic signed [15:0] mag;
    unique case (k[2:0])
      3'd0:    mag = 16'sd0;
      3'd1:    mag = 16'sd6270;
      3'd2:    mag = 16'sd11585;
      3'd3:    mag = 16'sd15137;
      3'd4:    mag = 16'sd16384;
      3'd5:    mag = 16'sd15137;
      3'd6:    mag = 16'sd11585;
      default: mag = 16'sd6270;
    endcase
    return k[3] ? -mag : mag;
  endfunction

  function automatic logic signed [2:0] gray_level(input logic [1:0] b);
    logic signed [2:0] lvl;
    unique case (b)
      2'b00:   lvl = -3'sd3;
      2'b01:   lvl = -3'sd1;
      2'b11:   lvl = 3'sd1;
      default: lvl = 3'sd3;
    endcase
    return lvl;
  endfunction

  assign last   = (cnt_q == 4'd15);
  assign ready  = (state_q == IDLE) || last;
  assign accept = bus.sym_valid && ready;

  assign sin_c  = coef(cnt_q);
  assign cos_c  = coef(cnt_q + 4'd4);
  assign prod_i = 19'(i_q) * 19'(cos_c);
  assign prod_q = 19'(q_q) * 19'(sin_c);
  assign sum    = 20'(prod_i) + 20'(prod_q);
  // Arithmetic shift gives floor rounding; the result always fits width_sym.
  assign sample = width_sym'(sum >>> SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    q_d     = q_q;
    data_d  = data_q;
    valid_d = valid_q;
    phase_d = phase_q;
    start_d = start_q;

    if (state_q == RUN) begin
      valid_d = 1'b1;
      data_d  = sample;
      phase_d = cnt_q;
      start_d = (cnt_q == 4'd0);
      cnt_d   = cnt_q + 4'd1;
      if (last && !accept) begin
        state_d = IDLE;
      end
    end else begin
      valid_d = 1'b0;
      data_d  = '0;
      phase_d = 4'd0;
      start_d = 1'b0;
    end

    // A wrap with a pending symbol restarts the counter on the same edge as sample 15.
    if (accept) begin
      i_d     = gray_level(bus.sym_in[3:2]);
      q_d     = gray_level(bus.sym_in[1:0]);
      cnt_d   = 4'd0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      i_q     <= 3'sd0;
      q_q     <= 3'sd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      phase_q <= 4'd0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      q_q     <= q_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
      start_q <= start_d;
    end
  end

  assign bus.sym_ready  = ready;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.phase      = phase_q;
  assign bus.sym_start  = start_q;

endmodule
